// File: rtl/bram_arb_pkg.sv
// Shared types for the two-requester BRAM arbiter: owner encoding,
// read-tag layout and the hold counter width helper.
package bram_arb_pkg;

  // Current owner of the memory port.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_0    = 2'd1,
    OWN_1    = 2'd2
  } owner_t;

  // Tag travelling alongside each forwarded read.
  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;

  // Width of the hold counter, never narrower than one bit so that
  // MAX_HOLD = 0 (no preemption) still elaborates.
  function automatic int hold_w(input int max_hold);
    int w;
    w = $clog2(max_hold + 1);
    return (w < 1) ? 1 : w;
  endfunction

  localparam int HOLD_W_DEFAULT = hold_w(16);

endpackage

// File: rtl/bram_arb2_if.sv
// Requester-side bundle of the arbiter.
// Handshake: a requester raises req and keeps it high until it is done;
// gnt is high in every cycle in which that requester owns the memory, and
// only accesses (r_req/addr/w_req/w_data) presented while gnt is high reach
// the memory. r_valid marks r_data as the answer to a read this requester
// issued READ_LAT cycles earlier.
interface bram_arb2_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req;
  logic              gnt;
  logic              r_req;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        w_req;
  logic [DATA_W-1:0] w_data;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;

  // Requester (conv engine, host/DMA loader) side.
  modport master (
    output req, r_req, addr, w_req, w_data,
    input  gnt, r_data, r_valid
  );

  // Arbiter side.
  modport slave (
    input  req, r_req, addr, w_req, w_data,
    output gnt, r_data, r_valid
  );
endinterface

// File: rtl/rd_tag_pipe.sv
// READ_LAT-deep shift register of read tags; its output lines up with the
// memory's read data so the data can be attributed to the issuer.
module rd_tag_pipe
  import bram_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t [DEPTH-1:0] stages;

  // Shift tags one stage per cycle; reset drops every pending read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stages <= '0;
    end else begin
      stages[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign tag_out = stages[DEPTH-1];

endmodule

// File: rtl/bram_arb2.sv
// Two-requester arbiter sharing one single-port BRAM. Ownership is granted
// from a registered owner state (round-robin on ties, optional hold limit),
// the owner's accesses are muxed combinationally onto the memory and read
// data is tagged back to the requester that issued the read.
module bram_arb2
  import bram_arb_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int READ_LAT = 1,
  parameter int MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              rst,
  bram_arb2_if.slave        r0,
  bram_arb2_if.slave        r1,
  output logic              m_r_req,
  output logic [ADDR_W-1:0] m_addr,
  output logic [3:0]        m_w_req,
  output logic [DATA_W-1:0] m_w_data,
  input  logic [DATA_W-1:0] m_r_data,
  output owner_t            dbg_state
);

  localparam int HOLD_W = hold_w(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  owner_t            state;
  owner_t            state_nxt;
  logic              last_owner;
  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_hit;
  tag_t              tag_in;
  tag_t              tag_out;

  // Owner has used up its hold allowance (only meaningful when enabled).
  assign hold_hit = (MAX_HOLD != 0) && (hold_cnt == HOLD_MAX);

  // Next owner: ties go to the requester that did not own last, a release
  // hands over directly to a waiting requester, and an expired hold
  // preempts the owner only while the other side is waiting.
  always_comb begin
    state_nxt = state;
    case (state)
      OWN_NONE: begin
        if (r0.req && r1.req) state_nxt = last_owner ? OWN_0 : OWN_1;
        else if (r0.req)      state_nxt = OWN_0;
        else if (r1.req)      state_nxt = OWN_1;
      end
      OWN_0: begin
        if (!r0.req)                state_nxt = r1.req ? OWN_1 : OWN_NONE;
        else if (hold_hit && r1.req) state_nxt = OWN_1;
      end
      OWN_1: begin
        if (!r1.req)                state_nxt = r0.req ? OWN_0 : OWN_NONE;
        else if (hold_hit && r0.req) state_nxt = OWN_0;
      end
      default: state_nxt = OWN_NONE;
    endcase
  end

  // Owner register, round-robin memory and saturating hold counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= OWN_NONE;
      last_owner <= 1'b1;
      hold_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        hold_cnt <= '0;
        if (state_nxt == OWN_0)      last_owner <= 1'b0;
        else if (state_nxt == OWN_1) last_owner <= 1'b1;
      end else if (state != OWN_NONE && hold_cnt != HOLD_MAX) begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end
    end
  end

  assign r0.gnt    = (state == OWN_0);
  assign r1.gnt    = (state == OWN_1);
  assign dbg_state = state;

  // Forward the owner's access; with no owner the memory sees an idle bus.
  always_comb begin
    m_r_req  = 1'b0;
    m_addr   = '0;
    m_w_req  = 4'h0;
    m_w_data = '0;
    case (state)
      OWN_0: begin
        m_r_req  = r0.r_req;
        m_addr   = r0.addr;
        m_w_req  = r0.w_req;
        m_w_data = r0.w_data;
      end
      OWN_1: begin
        m_r_req  = r1.r_req;
        m_addr   = r1.addr;
        m_w_req  = r1.w_req;
        m_w_data = r1.w_data;
      end
      default: ;
    endcase
  end

  // Tag each forwarded read with its issuer so the answer survives a handover.
  assign tag_in.valid = m_r_req;
  assign tag_in.id    = (state == OWN_1);

  rd_tag_pipe #(
    .DEPTH (READ_LAT)
  ) u_rd_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign r0.r_valid = tag_out.valid && !tag_out.id;
  assign r1.r_valid = tag_out.valid &&  tag_out.id;
  assign r0.r_data  = m_r_data;
  assign r1.r_data  = m_r_data;

endmodule

// File: tb/tb_bram_arb2.sv
// Bench for bram_arb2: directed scenarios plus a randomized run, all
// checked against an ownership/memory reference model kept in the bench.
module tb_bram_arb2;
  import bram_arb_pkg::*;

  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int MAXH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bram_arb2_if #(.DATA_W(DW), .ADDR_W(AW)) r0_if ();
  bram_arb2_if #(.DATA_W(DW), .ADDR_W(AW)) r1_if ();

  logic          m_r_req;
  logic [AW-1:0] m_addr;
  logic [3:0]    m_w_req;
  logic [DW-1:0] m_w_data;
  logic [DW-1:0] m_r_data;
  owner_t        dbg_state;

  bram_arb2 #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .READ_LAT (1),
    .MAX_HOLD (MAXH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .r0        (r0_if),
    .r1        (r1_if),
    .m_r_req   (m_r_req),
    .m_addr    (m_addr),
    .m_w_req   (m_w_req),
    .m_w_data  (m_w_data),
    .m_r_data  (m_r_data),
    .dbg_state (dbg_state)
  );

  // Single-port memory with one cycle read latency and byte enables.
  logic [31:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] <= 32'h1000_0000 + 32'(i * 7);
  always @(posedge clk) begin
    if (m_r_req) m_r_data <= mem[m_addr[7:0]];
    for (int b = 0; b < 4; b++)
      if (m_w_req[b]) mem[m_addr[7:0]][8*b +: 8] <= m_w_data[8*b +: 8];
  end

  // ---------------- reference model ----------------
  int          checks   = 0;
  int          failures = 0;
  int          mo       = -1;   // owner index, -1 when nobody owns
  int          mheld    = 0;    // owned cycles in the current tenure
  int          mlast    = 1;    // most recent owner
  logic [31:0] ref_mem [256];
  logic [DW-1:0] exp_q[$];      // read data due this cycle
  int          exp_id_q[$];     // issuer of that read

  initial for (int i = 0; i < 256; i++) ref_mem[i] = 32'h1000_0000 + 32'(i * 7);

  task automatic mdl_reset();
    mo = -1;
    mheld = 0;
    mlast = 1;
    exp_q.delete();
    exp_id_q.delete();
  endtask

  // Advance one clock edge and apply the arbitration rules to the model.
  task automatic step();
    int nxt;
    logic q0, q1, mine, other, rr;
    logic [7:0] a;
    logic [3:0] wr;
    logic [31:0] wd;
    @(posedge clk);
    exp_q.delete();
    exp_id_q.delete();
    if (!rst) begin
      mdl_reset();
    end else begin
      q0 = r0_if.req;
      q1 = r1_if.req;
      if (mo >= 0) begin
        rr = (mo == 0) ? r0_if.r_req       : r1_if.r_req;
        a  = (mo == 0) ? r0_if.addr[7:0]   : r1_if.addr[7:0];
        wr = (mo == 0) ? r0_if.w_req       : r1_if.w_req;
        wd = (mo == 0) ? r0_if.w_data      : r1_if.w_data;
        if (rr) begin
          exp_q.push_back(ref_mem[a]);
          exp_id_q.push_back(mo);
        end
        for (int b = 0; b < 4; b++) if (wr[b]) ref_mem[a][8*b +: 8] = wd[8*b +: 8];
      end
      if (mo < 0) begin
        nxt = (q0 && q1) ? 1 - mlast : q0 ? 0 : q1 ? 1 : -1;
      end else begin
        mine  = (mo == 0) ? q0 : q1;
        other = (mo == 0) ? q1 : q0;
        if (!mine)                                 nxt = other ? 1 - mo : -1;
        else if (MAXH != 0 && mheld >= MAXH && other) nxt = 1 - mo;
        else                                       nxt = mo;
      end
      if (nxt != mo) begin
        mheld = (nxt >= 0) ? 1 : 0;
        if (nxt >= 0) mlast = nxt;
      end else if (mo >= 0) begin
        mheld++;
      end
      mo = nxt;
    end
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input int n, input logic rq, input logic rr, input logic [7:0] a,
                       input logic [3:0] w, input logic [31:0] d);
    if (n == 0) begin
      r0_if.req = rq; r0_if.r_req = rr; r0_if.addr = AW'(a); r0_if.w_req = w; r0_if.w_data = d;
    end else begin
      r1_if.req = rq; r1_if.r_req = rr; r1_if.addr = AW'(a); r1_if.w_req = w; r1_if.w_data = d;
    end
  endtask

  task automatic idle_all();
    drive(0, 1'b0, 1'b0, 8'h0, 4'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 8'h0, 4'h0, 32'h0);
  endtask

  task automatic drive_random(input int n);
    drive(n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
          4'($urandom_range(0, 15)), $urandom);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [DW+AW+9:0] obs;
    rst = 1'b0;
    mdl_reset();
    for (int i = 0; i < 8; i++) begin
      drive_random(0);
      drive_random(1);
      #1;
      obs = {r0_if.gnt, r1_if.gnt, r0_if.r_valid, r1_if.r_valid, m_r_req, m_w_req, m_addr, m_w_data};
      checks++;
      if (obs !== '0 || dbg_state !== OWN_NONE) begin
        failures++;
        $display("FAIL reset_outputs cycle=%0d got outputs=%h state=%0d want outputs=0 state=0",
                 i, obs, dbg_state);
      end
      step();
    end
    idle_all();
    #1 rst = 1'b1;
    step();
  endtask

  task automatic test_single();
    idle_all();
    drive(0, 1'b1, 1'b0, 8'h0, 4'h0, 32'h0);
    #1;
    checks++;
    if (r0_if.gnt !== 1'b0) begin
      failures++; $display("FAIL single_gnt_early got=%b want=0", r0_if.gnt);
    end
    step();
    checks++;
    if (r0_if.gnt !== 1'b1 || r1_if.gnt !== 1'b0) begin
      failures++; $display("FAIL single_gnt got=%b%b want=10", r0_if.gnt, r1_if.gnt);
    end
    drive(0, 1'b1, 1'b0, 8'd5, 4'hF, 32'hDEADBEEF);
    #1;
    checks++;
    if (m_w_req !== 4'hF || m_addr !== 32'd5 || m_w_data !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL single_write_fwd got w_req=%h addr=%h data=%h want F/5/DEADBEEF", m_w_req, m_addr, m_w_data);
    end
    step();
    drive(0, 1'b1, 1'b1, 8'd5, 4'h0, 32'h0);
    step();
    checks++;
    if (r0_if.r_valid !== 1'b1 || r1_if.r_valid !== 1'b0 || r0_if.r_data !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL single_read got rv0=%b rv1=%b data=%h want 1/0/DEADBEEF",
               r0_if.r_valid, r1_if.r_valid, r0_if.r_data);
    end
    drive(0, 1'b0, 1'b0, 8'h0, 4'h0, 32'h0);
    step();
    checks++;
    if (r0_if.gnt !== 1'b0 || r0_if.r_valid !== 1'b0) begin
      failures++; $display("FAIL single_release got gnt0=%b rv0=%b want 0/0", r0_if.gnt, r0_if.r_valid);
    end
  endtask

  task automatic test_tie();
    idle_all();
    rst = 1'b0;
    mdl_reset();
    #2 rst = 1'b1;
    drive(0, 1'b1, 1'b0, 8'h0, 4'h0, 32'h0);
    drive(1, 1'b1, 1'b0, 8'h0, 4'h0, 32'h0);
    step();
    checks++;
    if (r0_if.gnt !== 1'b1 || r1_if.gnt !== 1'b0) begin
      failures++; $display("FAIL tie_first got=%b%b want=10", r0_if.gnt, r1_if.gnt);
    end
    drive(0, 1'b0, 1'b0, 8'h0, 4'h0, 32'h0);
    step();
    checks++;
    if (r0_if.gnt !== 1'b0 || r1_if.gnt !== 1'b1) begin
      failures++; $display("FAIL tie_handover got=%b%b want=01", r0_if.gnt, r1_if.gnt);
    end
    idle_all();
    step();
  endtask

  task automatic test_preempt();
    idle_all();
    drive(1, 1'b1, 1'b0, 8'h0, 4'h0, 32'h0);
    step();
    drive(0, 1'b1, 1'b0, 8'h0, 4'h0, 32'h0);
    checks++;
    if (r1_if.gnt !== 1'b1) begin
      failures++; $display("FAIL preempt_grant got gnt1=%b want=1", r1_if.gnt);
    end
    for (int i = 2; i <= MAXH; i++) begin
      step();
      checks++;
      if (r1_if.gnt !== 1'b1 || r0_if.gnt !== 1'b0) begin
        failures++; $display("FAIL preempt_hold owned_cycle=%0d got=%b%b want=01", i, r0_if.gnt, r1_if.gnt);
      end
    end
    step();
    checks++;
    if (r0_if.gnt !== 1'b1 || r1_if.gnt !== 1'b0) begin
      failures++; $display("FAIL preempt_switch got=%b%b want=10", r0_if.gnt, r1_if.gnt);
    end
    step();
    drive(0, 1'b0, 1'b0, 8'h0, 4'h0, 32'h0);
    step();
    checks++;
    if (r0_if.gnt !== 1'b0 || r1_if.gnt !== 1'b1) begin
      failures++; $display("FAIL preempt_regain got=%b%b want=01", r0_if.gnt, r1_if.gnt);
    end
    idle_all();
    step();
  endtask

  task automatic test_handover();
    logic [31:0] val;
    val = $urandom;
    idle_all();
    drive(0, 1'b1, 1'b0, 8'd9, 4'hF, val);
    step();
    step();
    drive(1, 1'b1, 1'b0, 8'h0, 4'h0, 32'h0);
    drive(0, 1'b0, 1'b1, 8'd9, 4'h0, 32'h0);
    step();
    checks++;
    if (r1_if.gnt !== 1'b1 || r0_if.gnt !== 1'b0 || r0_if.r_valid !== 1'b1 ||
        r1_if.r_valid !== 1'b0 || r0_if.r_data !== val) begin
      failures++;
      $display("FAIL handover_read got gnt=%b%b rv=%b%b data=%h want gnt=01 rv=10 data=%h",
               r0_if.gnt, r1_if.gnt, r0_if.r_valid, r1_if.r_valid, r0_if.r_data, val);
    end
    idle_all();
    step();
  endtask

  task automatic test_isolation();
    logic [31:0] keep;
    keep = ref_mem[3];
    idle_all();
    drive(0, 1'b1, 1'b0, 8'h0, 4'h0, 32'h0);
    step();
    drive(1, 1'b0, 1'b0, 8'd3, 4'hF, ~keep);
    #1;
    checks++;
    if (m_w_req !== 4'h0) begin
      failures++; $display("FAIL iso_wreq got=%h want=0", m_w_req);
    end
    step();
    drive(1, 1'b0, 1'b0, 8'h0, 4'h0, 32'h0);
    drive(0, 1'b1, 1'b1, 8'd3, 4'h0, 32'h0);
    step();
    checks++;
    if (r0_if.r_valid !== 1'b1 || r0_if.r_data !== keep) begin
      failures++; $display("FAIL iso_mem got rv=%b data=%h want 1/%h", r0_if.r_valid, r0_if.r_data, keep);
    end
    drive(0, 1'b1, 1'b1, 8'd4, 4'h0, 32'h0);
    step();
    rst = 1'b0;
    mdl_reset();
    idle_all();
    #1;
    checks++;
    if (r0_if.r_valid !== 1'b0 || r1_if.r_valid !== 1'b0 || r0_if.gnt !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_read got rv=%b%b gnt0=%b want 00/0", r0_if.r_valid, r1_if.r_valid, r0_if.gnt);
    end
    #2 rst = 1'b1;
    step();
  endtask

  task automatic test_random();
    logic q [2];
    logic [3:0]    ew;
    logic          er;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          erv0, erv1;
    q[0] = 1'b0;
    q[1] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int n = 0; n < 2; n++) begin
        if ($urandom_range(0, 5) == 0) q[n] = ~q[n];
        drive(n, q[n], ($urandom_range(0, 2) == 0), 8'($urandom_range(0, 15)),
              ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0, $urandom);
      end
      #1;
      ew = (mo == 0) ? r0_if.w_req  : (mo == 1) ? r1_if.w_req  : 4'h0;
      er = (mo == 0) ? r0_if.r_req  : (mo == 1) ? r1_if.r_req  : 1'b0;
      ea = (mo == 0) ? r0_if.addr   : (mo == 1) ? r1_if.addr   : '0;
      ed = (mo == 0) ? r0_if.w_data : (mo == 1) ? r1_if.w_data : '0;
      checks++;
      if (m_w_req !== ew || m_r_req !== er || m_addr !== ea || m_w_data !== ed) begin
        failures++;
        $display("FAIL rand_mux cycle=%0d got r=%b w=%h a=%h d=%h want r=%b w=%h a=%h d=%h",
                 c, m_r_req, m_w_req, m_addr, m_w_data, er, ew, ea, ed);
      end
      step();
      checks++;
      if (r0_if.gnt !== (mo == 0) || r1_if.gnt !== (mo == 1)) begin
        failures++;
        $display("FAIL rand_gnt cycle=%0d got=%b%b want owner=%0d", c, r0_if.gnt, r1_if.gnt, mo);
      end
      erv0 = (exp_id_q.size() > 0) && (exp_id_q[0] == 0);
      erv1 = (exp_id_q.size() > 0) && (exp_id_q[0] == 1);
      checks++;
      if (r0_if.r_valid !== erv0 || r1_if.r_valid !== erv1) begin
        failures++;
        $display("FAIL rand_rvalid cycle=%0d got=%b%b want=%b%b", c, r0_if.r_valid, r1_if.r_valid, erv0, erv1);
      end
      if (exp_q.size() > 0) begin
        checks++;
        if (r0_if.r_data !== exp_q[0]) begin
          failures++;
          $display("FAIL rand_rdata cycle=%0d got=%h want=%h", c, r0_if.r_data, exp_q[0]);
        end
      end
    end
    idle_all();
    step();
    step();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    idle_all();
    test_reset();
    test_single();
    test_tie();
    test_preempt();
    test_handover();
    test_isolation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
